stack_round_ctrl: RTL

//  Per-round sequencer for the block-stacker game. Slides the current block left/right across the row,

---
 rtl/stack_pkg.sv | 37 +++
 rtl/stack_overlap_calc.sv | 42 ++++
 rtl/stack_round_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared types and constants for the block-stacker round
//               sequencer: FSM state encoding, default geometry and the
//               slide-period helper used when SPEED_RAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

  localparam int X_W      = 9;
  localparam int SCREEN_W = 160;
  localparam int UNIT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DRAW  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_t;

  // Slide period for a row: shrinks by div/16 per row, floored at div/4.
  function automatic logic [31:0] ramp_period(input logic [3:0] row,
                                              input logic [31:0] div);
    logic [31:0] dec;
    logic [31:0] lo;
    dec = 32'(row) * (div >> 4);
    lo  = div >> 2;
    if ((dec >= div) || ((div - dec) < lo)) return lo;
    return div - dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_overlap_calc.sv
`default_nettype none
// ============================================================================
// Module      : stack_overlap_calc
// Description : Combinational overlap of the frozen block with the block
//               below. Produces the miss flag, the overlap left pixel and the
//               trimmed size in units.
// Ports       : prev_start_i/prev_end_i - bounds of the block below
//               curr_start_i/curr_end_i - bounds of the frozen block
//               miss_o                  - no horizontal overlap
//               ov_start_o              - overlap left pixel
//               ov_size_o               - overlap width in units
// Revision    : 1.0 - initial release
// ============================================================================
module stack_overlap_calc #(
  parameter int X_W  = 9,
  parameter int UNIT = 8
) (
  input  logic [X_W-1:0] prev_start_i,
  input  logic [X_W-1:0] prev_end_i,
  input  logic [X_W-1:0] curr_start_i,
  input  logic [X_W-1:0] curr_end_i,
  output logic           miss_o,
  output logic [X_W-1:0] ov_start_o,
  output logic [3:0]     ov_size_o
);
  import stack_pkg::*;

  logic [X_W-1:0] w_ov_end;
  logic [X_W:0]   w_width;

  always_comb begin
    miss_o     = (curr_start_i > prev_end_i) || (curr_end_i < prev_start_i);
    ov_start_o = (curr_start_i > prev_start_i) ? curr_start_i : prev_start_i;
    w_ov_end   = (curr_end_i < prev_end_i) ? curr_end_i : prev_end_i;
    // Positions are UNIT-aligned, so the division is exact. Value is
    // meaningless on a miss and is not used then.
    w_width    = {1'b0, w_ov_end} - {1'b0, ov_start_o} + {{X_W{1'b0}}, 1'b1};
    ov_size_o  = 4'(32'(w_width) / 32'(UNIT));
  end

endmodule
`default_nettype wire

// File: rtl/stack_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_round_ctrl
// Description : Per-round sequencer for the block stacker. Slides the current
//               block, freezes it on stop, trims it to the overlap with the
//               block below, requests a draw and advances rows. Owns all
//               block geometry, score and win/lose state.
// Config      : SPEED_RAMP_EN - when defined, the slide period shortens with
//               each row; otherwise it is a constant MOVE_DIV.
// Ports       : clk, resetn (async, active low)
//               start_i, stop_pulse_i, draw_done_i   - control inputs
//               curr_start_o/curr_end_o/curr_size_o  - sliding block
//               prev_start_o/prev_end_o              - block below
//               row_idx_o, draw_req_o, score_o, game_over_o, win_o
// Revision    : 1.0 - initial release
// ============================================================================
module stack_round_ctrl #(
  parameter int X_W       = stack_pkg::X_W,
  parameter int SCREEN_W  = stack_pkg::SCREEN_W,
  parameter int UNIT      = stack_pkg::UNIT,
  parameter int INIT_SIZE = 4,
  parameter int ROWS      = 12,
  parameter int MOVE_DIV  = 2_000_000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start_i,
  input  logic           stop_pulse_i,
  input  logic           draw_done_i,
  output logic [X_W-1:0] curr_start_o,
  output logic [X_W-1:0] curr_end_o,
  output logic [3:0]     curr_size_o,
  output logic [X_W-1:0] prev_start_o,
  output logic [X_W-1:0] prev_end_o,
  output logic [3:0]     row_idx_o,
  output logic           draw_req_o,
  output logic [7:0]     score_o,
  output logic           game_over_o,
  output logic           win_o
);
  import stack_pkg::*;

  state_t         state_q;
  logic [X_W-1:0] curr_start_q, prev_start_q, prev_end_q;
  logic [3:0]     size_q, row_q;
  logic [7:0]     score_q;
  logic           draw_req_q, game_over_q, win_q, dir_left_q;
  logic [31:0]    cnt_q, period_q;

  logic [31:0]    w_span;
  logic [X_W-1:0] w_curr_end, w_step_start, w_ov_start;
  logic           w_tick, w_bounce, w_miss;
  logic [3:0]     w_ov_size;
  logic [8:0]     w_score_sum;
  logic [31:0]    w_period_row0, w_period_next;

  // End pixel is always derived; a zero size (reset) reports 0, not -1.
  assign w_span     = 32'(size_q) * 32'(UNIT);
  assign w_curr_end = (size_q == 4'd0) ? '0 :
                      X_W'(32'(curr_start_q) + w_span - 32'd1);

  assign w_tick = (cnt_q == (period_q - 32'd1));
  assign w_bounce = dir_left_q ? (32'(curr_start_q) < 32'(UNIT)) :
                    ((32'(curr_start_q) + 32'(UNIT) + w_span) > 32'(SCREEN_W));
  assign w_step_start = dir_left_q ? (curr_start_q - X_W'(UNIT)) :
                                     (curr_start_q + X_W'(UNIT));
  assign w_score_sum = {1'b0, score_q} + {5'b0, size_q};

`ifdef SPEED_RAMP_EN
  assign w_period_row0 = ramp_period(4'd0, 32'(MOVE_DIV));
  assign w_period_next = ramp_period(row_q + 4'd1, 32'(MOVE_DIV));
`else
  assign w_period_row0 = 32'(MOVE_DIV);
  assign w_period_next = 32'(MOVE_DIV);
`endif

  stack_overlap_calc #(.X_W(X_W), .UNIT(UNIT)) u_overlap (
    .prev_start_i (prev_start_q),
    .prev_end_i   (prev_end_q),
    .curr_start_i (curr_start_q),
    .curr_end_i   (w_curr_end),
    .miss_o       (w_miss),
    .ov_start_o   (w_ov_start),
    .ov_size_o    (w_ov_size)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      curr_start_q <= '0;
      prev_start_q <= '0;
      prev_end_q   <= '0;
      size_q       <= '0;
      row_q        <= '0;
      score_q      <= '0;
      draw_req_q   <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
      dir_left_q   <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (start_i) begin
            prev_start_q <= '0;
            prev_end_q   <= X_W'(SCREEN_W - 1);
            curr_start_q <= '0;
            size_q       <= 4'(INIT_SIZE);
            row_q        <= '0;
            score_q      <= '0;
            dir_left_q   <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
            cnt_q        <= '0;
            period_q     <= w_period_row0;
            state_q      <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          // Stop has priority: a coincident tick is discarded.
          if (stop_pulse_i) begin
            state_q <= ST_CHECK;
          end else if (w_tick) begin
            cnt_q <= '0;
            if (w_bounce) dir_left_q   <= ~dir_left_q;
            else          curr_start_q <= w_step_start;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_CHECK: begin
          if (w_miss) begin
            game_over_q <= 1'b1;
            state_q     <= ST_OVER;
          end else begin
            curr_start_q <= w_ov_start;
            size_q       <= w_ov_size;
            draw_req_q   <= 1'b1;
            state_q      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (draw_done_i) begin
            draw_req_q <= 1'b0;
            state_q    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          score_q <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
          if (row_q == 4'(ROWS - 1)) begin
            win_q   <= 1'b1;
            state_q <= ST_WIN;
          end else begin
            row_q        <= row_q + 4'd1;
            prev_start_q <= curr_start_q;
            prev_end_q   <= w_curr_end;
            curr_start_q <= '0;
            dir_left_q   <= 1'b0;
            cnt_q        <= '0;
            period_q     <= w_period_next;
            state_q      <= ST_MOVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign curr_start_o = curr_start_q;
  assign curr_end_o   = w_curr_end;
  assign curr_size_o  = size_q;
  assign prev_start_o = prev_start_q;
  assign prev_end_o   = prev_end_q;
  assign row_idx_o    = row_q;
  assign draw_req_o   = draw_req_q;
  assign score_o      = score_q;
  assign game_over_o  = game_over_q;
  assign win_o        = win_q;

endmodule
`default_nettype wire
